// File: rtl/multicycle_controller.sv
// Multicycle MIPS control unit: Moore FSM over one shared memory port and ALU, with a
// bounded mem_ready wait. Define MULTICYCLE_BNE_EN to add bne support.
module multicycle_controller #(
   parameter int ALUC_W  = 3,
   parameter int TIMEOUT = 16,
   parameter int CNT_W   = 5
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [5:0]        opcode,
   input  logic [5:0]        funct,
   input  logic              zero,
   input  logic              mem_ready,
   output logic              MemRead,
   output logic              MemWrite,
   output logic              IorD,
   output logic              IRWrite,
   output logic              RegDst,
   output logic              MemToReg,
   output logic              RegWrite,
   output logic              ALUSrcA,
   output logic [1:0]        ALUSrcB,
   output logic [1:0]        PCSrc,
   output logic              PCWrite,
   output logic [ALUC_W-1:0] alucontrol,
   output logic [1:0]        LoadByte,
   output logic              mem_timeout,
   output logic [3:0]        state
);

   typedef enum logic [3:0] {
      S_FETCH  = 4'd0,  S_DECODE = 4'd1,  S_MEMADR = 4'd2,  S_MEMRD  = 4'd3,
      S_MEMWB  = 4'd4,  S_MEMWR  = 4'd5,  S_EXEC   = 4'd6,  S_ALUWB  = 4'd7,
      S_BRANCH = 4'd8,  S_ADDIEX = 4'd9,  S_ADDIWB = 4'd10, S_JUMP   = 4'd11
   } state_e;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_LB    = 6'b100000;
   localparam logic [5:0] OP_LBU   = 6'b100100;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_J     = 6'b000010;
`ifdef MULTICYCLE_BNE_EN
   localparam logic [5:0] OP_BNE   = 6'b000101;
`endif

   localparam logic [2:0] ALU_ADD = 3'b010;
   localparam logic [2:0] ALU_SUB = 3'b110;
   localparam logic [2:0] ALU_AND = 3'b000;
   localparam logic [2:0] ALU_OR  = 3'b001;
   localparam logic [2:0] ALU_SLT = 3'b111;

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

   state_e           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             timeout_q, timeout_d;
   logic             mem_state;
   state_e           mem_next;
   logic [2:0]       alu_code;

   always_comb begin
      // NOTE: every variable gets a default before the case so no path can infer a latch.
      state_d   = S_FETCH;
      cnt_d     = '0;
      timeout_d = 1'b0;
      mem_state = 1'b0;
      mem_next  = S_FETCH;
      case (state_q)
         S_FETCH:  begin mem_state = 1'b1; mem_next = S_DECODE; end
         S_DECODE: begin
            case (opcode)
               OP_RTYPE:                    state_d = S_EXEC;
               OP_LW, OP_SW, OP_LB, OP_LBU: state_d = S_MEMADR;
               OP_BEQ:                      state_d = S_BRANCH;
`ifdef MULTICYCLE_BNE_EN
               OP_BNE:                      state_d = S_BRANCH;
`endif
               OP_ADDI:                     state_d = S_ADDIEX;
               OP_J:                        state_d = S_JUMP;
               default:                     state_d = S_FETCH;
            endcase
         end
         S_MEMADR: state_d = (opcode == OP_SW) ? S_MEMWR : S_MEMRD;
         S_MEMRD:  begin mem_state = 1'b1; mem_next = S_MEMWB; end
         S_MEMWR:  begin mem_state = 1'b1; mem_next = S_FETCH; end
         S_EXEC:   state_d = S_ALUWB;
         S_ADDIEX: state_d = S_ADDIWB;
         default:  state_d = S_FETCH;
      endcase
      // A late mem_ready on the last allowed cycle still completes the access.
      if (mem_state) begin
         if (mem_ready) begin
            state_d = mem_next;
         end else if (cnt_q == CNT_LAST) begin
            state_d   = S_FETCH;
            timeout_d = 1'b1;
         end else begin
            state_d = state_q;
            cnt_d   = cnt_q + CNT_W'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments only.
      if (!reset) begin
         state_q   <= S_FETCH;
         cnt_q     <= '0;
         timeout_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         timeout_q <= timeout_d;
      end
   end

   always_comb begin
      MemRead  = 1'b0;  MemWrite = 1'b0;  IorD     = 1'b0;  IRWrite  = 1'b0;
      RegDst   = 1'b0;  MemToReg = 1'b0;  RegWrite = 1'b0;  ALUSrcA  = 1'b0;
      ALUSrcB  = 2'b00; PCSrc    = 2'b00; PCWrite  = 1'b0;  alu_code = ALU_AND;
      LoadByte = 2'b00;
      case (state_q)
         S_FETCH: begin
            MemRead  = 1'b1;
            ALUSrcB  = 2'b01;
            alu_code = ALU_ADD;
            IRWrite  = mem_ready;
            PCWrite  = mem_ready;
         end
         S_DECODE: begin ALUSrcB = 2'b11; alu_code = ALU_ADD; end
         S_MEMADR, S_ADDIEX: begin ALUSrcA = 1'b1; ALUSrcB = 2'b10; alu_code = ALU_ADD; end
         S_MEMRD:  begin MemRead = 1'b1; IorD = 1'b1; end
         S_MEMWB: begin
            MemToReg = 1'b1;
            RegWrite = 1'b1;
            LoadByte = (opcode == OP_LB) ? 2'b01 : (opcode == OP_LBU) ? 2'b10 : 2'b00;
         end
         S_MEMWR:  begin MemWrite = 1'b1; IorD = 1'b1; end
         S_EXEC: begin
            ALUSrcA = 1'b1;
            case (funct)
               6'b100010: alu_code = ALU_SUB;
               6'b100100: alu_code = ALU_AND;
               6'b100101: alu_code = ALU_OR;
               6'b101010: alu_code = ALU_SLT;
               default:   alu_code = ALU_ADD;
            endcase
         end
         S_ALUWB:  begin RegDst = 1'b1; RegWrite = 1'b1; end
         S_BRANCH: begin
            ALUSrcA  = 1'b1;
            alu_code = ALU_SUB;
            PCSrc    = 2'b01;
`ifdef MULTICYCLE_BNE_EN
            PCWrite  = (opcode == OP_BNE) ? ~zero : zero;
`else
            PCWrite  = zero;
`endif
         end
         S_ADDIWB: RegWrite = 1'b1;
         S_JUMP:   begin PCSrc = 2'b10; PCWrite = 1'b1; end
         default: ;
      endcase
      // Architectural writes are suppressed while reset is held, even mid-access.
      if (!reset) begin
         IRWrite  = 1'b0;
         PCWrite  = 1'b0;
         RegWrite = 1'b0;
         MemWrite = 1'b0;
      end
   end

   assign alucontrol  = ALUC_W'(alu_code);
   assign mem_timeout = timeout_q;
   assign state       = state_q;

endmodule

// File: tb/tb_multicycle_controller.sv
// Bench for multicycle_controller: directed steps from the test plan, then random
// instruction streams checked against a per-instruction path model.
module tb_multicycle_controller;

   localparam int TIMEOUT = 16;

   logic       clk, reset, zero, mem_ready;
   logic [5:0] opcode, funct;
   logic       MemRead, MemWrite, IorD, IRWrite, RegDst, MemToReg, RegWrite, ALUSrcA;
   logic [1:0] ALUSrcB, PCSrc, LoadByte;
   logic       PCWrite, mem_timeout;
   logic [2:0] alucontrol;
   logic [3:0] state;

   int checks = 0;
   int errors = 0;

   multicycle_controller #(.ALUC_W(3), .TIMEOUT(TIMEOUT), .CNT_W(5)) dut (
      .clk(clk), .reset(reset), .opcode(opcode), .funct(funct), .zero(zero),
      .mem_ready(mem_ready), .MemRead(MemRead), .MemWrite(MemWrite), .IorD(IorD),
      .IRWrite(IRWrite), .RegDst(RegDst), .MemToReg(MemToReg), .RegWrite(RegWrite),
      .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .PCSrc(PCSrc), .PCWrite(PCWrite),
      .alucontrol(alucontrol), .LoadByte(LoadByte), .mem_timeout(mem_timeout),
      .state(state)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct packed {
      logic mr, mw, iord, irw, rd, m2r, rw, asa;
      logic [1:0] asb, pcs;
      logic pcw;
      logic [2:0] alu;
      logic [1:0] lb;
   } outs_t;

   outs_t act;
   assign act = {MemRead, MemWrite, IorD, IRWrite, RegDst, MemToReg, RegWrite, ALUSrcA,
                 ALUSrcB, PCSrc, PCWrite, alucontrol, LoadByte};

   // Spec state codes.
   localparam int F = 0, D = 1, MA = 2, MR = 3, MWB = 4, MW = 5;
   localparam int EX = 6, AWB = 7, BR = 8, AIE = 9, AIW = 10, JP = 11;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [2:0] alu_of_funct(input logic [5:0] fn);
      case (fn)
         6'b100000: return 3'b010;
         6'b100010: return 3'b110;
         6'b100100: return 3'b000;
         6'b100101: return 3'b001;
         6'b101010: return 3'b111;
         default:   return 3'b010;
      endcase
   endfunction

   // Output table of the specification, indexed by state code.
   function automatic outs_t exp_outs(input int st, input logic [5:0] op, input logic [5:0] fn,
                                      input logic z, input logic rdy);
      outs_t o = '0;
      case (st)
         F:   begin o.mr = 1; o.asb = 2'b01; o.alu = 3'b010; o.irw = rdy; o.pcw = rdy; end
         D:   begin o.asb = 2'b11; o.alu = 3'b010; end
         MA:  begin o.asa = 1; o.asb = 2'b10; o.alu = 3'b010; end
         MR:  begin o.mr = 1; o.iord = 1; end
         MWB: begin
            o.m2r = 1; o.rw = 1;
            o.lb = (op == 6'b100000) ? 2'b01 : (op == 6'b100100) ? 2'b10 : 2'b00;
         end
         MW:  begin o.mw = 1; o.iord = 1; end
         EX:  begin o.asa = 1; o.alu = alu_of_funct(fn); end
         AWB: begin o.rd = 1; o.rw = 1; end
         BR:  begin
            o.asa = 1; o.alu = 3'b110; o.pcs = 2'b01;
            o.pcw = (op == 6'b000101) ? ~z : z;
         end
         AIE: begin o.asa = 1; o.asb = 2'b10; o.alu = 3'b010; end
         AIW: o.rw = 1;
         JP:  begin o.pcs = 2'b10; o.pcw = 1; end
         default: ;
      endcase
      return o;
   endfunction

   typedef struct {
      int st;
      logic rdy, z, tmo;
      logic [5:0] op, fn;
   } cyc_t;

   cyc_t q[$];
   logic pend_tmo = 1'b0;

   function automatic void push_cyc(input int st, input logic rdy, input logic z,
                                    input logic [5:0] op, input logic [5:0] fn);
      cyc_t c;
      c.st = st; c.rdy = rdy; c.z = z; c.op = op; c.fn = fn; c.tmo = pend_tmo;
      pend_tmo = 1'b0;
      q.push_back(c);
   endfunction

   // A memory wait of `waits` idle cycles; returns 0 if it aborts on timeout.
   function automatic bit mem_phase(input int st, input int waits, input logic z,
                                    input logic [5:0] op, input logic [5:0] fn);
      int idle = (waits >= TIMEOUT) ? TIMEOUT : waits;
      for (int i = 0; i < idle; i++) push_cyc(st, 1'b0, z, op, fn);
      if (waits >= TIMEOUT) begin
         pend_tmo = 1'b1;
         return 1'b0;
      end
      push_cyc(st, 1'b1, z, op, fn);
      return 1'b1;
   endfunction

   function automatic int pick_wait();
      int r = int'($urandom_range(0, 11));
      if (r == 0) return TIMEOUT;
      if (r == 1) return TIMEOUT - 1;
      return int'($urandom_range(0, 3));
   endfunction

   logic [5:0] op_list [10] = '{6'b000000, 6'b100011, 6'b101011, 6'b100000, 6'b100100,
                                6'b000100, 6'b001000, 6'b000010, 6'b111111, 6'b000101};
   logic [5:0] fn_list [6]  = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010,
                                6'b000011};

   initial begin
      reset = 1'b0; mem_ready = 1'b1; zero = 1'b0;
      opcode = 6'b000000; funct = 6'b101010;

      // Reset held two cycles, then R-type slt.
      next_cycle(); #1;
      check("rst_state", 32'(state), 32'd0);
      check("rst_pcwrite", 32'(PCWrite), 32'd0);
      check("rst_irwrite", 32'(IRWrite), 32'd0);
      check("rst_memread", 32'(MemRead), 32'd1);
      check("rst_tmo", 32'(mem_timeout), 32'd0);
      next_cycle(); reset = 1'b1; #1;
      check("post_rst_state", 32'(state), 32'd0);
      check("post_rst_memread", 32'(MemRead), 32'd1);
      check("post_rst_pcwrite", 32'(PCWrite), 32'd1);
      check("post_rst_irwrite", 32'(IRWrite), 32'd1);
      next_cycle(); #1;
      check("r_decode", 32'(state), 32'd1);
      check("r_decode_srcb", 32'(ALUSrcB), 32'd3);
      next_cycle(); #1;
      check("r_exec", 32'(state), 32'd6);
      check("r_exec_alu", 32'(alucontrol), 32'b111);
      next_cycle(); #1;
      check("r_aluwb", 32'(state), 32'd7);
      check("r_aluwb_regwrite", 32'(RegWrite), 32'd1);
      check("r_aluwb_regdst", 32'(RegDst), 32'd1);
      opcode = 6'b100000;
      next_cycle(); #1;
      check("r_back_fetch", 32'(state), 32'd0);

      // lb with three stalled MEMRD cycles.
      next_cycle(); #1;
      check("lb_decode", 32'(state), 32'd1);
      next_cycle(); mem_ready = 1'b0; #1;
      check("lb_memadr", 32'(state), 32'd2);
      for (int i = 0; i < 3; i++) begin
         next_cycle(); mem_ready = 1'b0; #1;
         check("lb_memrd_wait", 32'(state), 32'd3);
         check("lb_memrd_read", 32'({MemRead, IorD}), 32'b11);
      end
      next_cycle(); mem_ready = 1'b1; #1;
      check("lb_memrd_last", 32'(state), 32'd3);
      next_cycle(); #1;
      check("lb_memwb", 32'(state), 32'd4);
      check("lb_loadbyte", 32'(LoadByte), 32'b01);
      check("lb_regwrite", 32'(RegWrite), 32'd1);

      // beq taken then not taken.
      opcode = 6'b000100; zero = 1'b1;
      next_cycle(); #1;
      next_cycle(); #1;
      next_cycle(); #1;
      check("beq_t_state", 32'(state), 32'd8);
      check("beq_t_pcwrite", 32'(PCWrite), 32'd1);
      check("beq_t_pcsrc", 32'(PCSrc), 32'b01);
      zero = 1'b0;
      next_cycle(); #1;
      next_cycle(); #1;
      next_cycle(); #1;
      check("beq_nt_state", 32'(state), 32'd8);
      check("beq_nt_pcwrite", 32'(PCWrite), 32'd0);

      // FETCH timeout after 16 idle cycles, then illegal opcode.
      for (int i = 0; i < TIMEOUT; i++) begin
         next_cycle(); mem_ready = 1'b0; #1;
         check("tmo_fetch_state", 32'(state), 32'd0);
         check("tmo_fetch_irwrite", 32'(IRWrite), 32'd0);
         check("tmo_fetch_pulse", 32'(mem_timeout), 32'd0);
      end
      opcode = 6'b111111;
      next_cycle(); mem_ready = 1'b1; #1;
      check("tmo_pulse", 32'(mem_timeout), 32'd1);
      check("tmo_pulse_state", 32'(state), 32'd0);
      next_cycle(); #1;
      check("illegal_decode", 32'(state), 32'd1);
      check("illegal_pulse_gone", 32'(mem_timeout), 32'd0);
      check("illegal_regwrite", 32'(RegWrite), 32'd0);
      next_cycle(); mem_ready = 1'b0; opcode = 6'b101011; #1;
      check("illegal_to_fetch", 32'(state), 32'd0);
      check("illegal_no_regwrite", 32'(RegWrite), 32'd0);

      // mem_ready on the 16th FETCH cycle wins over the timeout; then sw with reset.
      for (int i = 1; i < TIMEOUT - 1; i++) begin
         next_cycle(); #1;
         check("late_fetch_state", 32'(state), 32'd0);
      end
      next_cycle(); mem_ready = 1'b1; #1;
      check("late_fetch_irwrite", 32'(IRWrite), 32'd1);
      next_cycle(); #1;
      check("late_decode", 32'(state), 32'd1);
      check("late_no_tmo", 32'(mem_timeout), 32'd0);
      next_cycle(); #1;
      check("sw_memadr", 32'(state), 32'd2);
      next_cycle(); mem_ready = 1'b0; #1;
      check("sw_memwr", 32'(state), 32'd5);
      check("sw_memwrite", 32'(MemWrite), 32'd1);
      reset = 1'b0;
      next_cycle(); #1;
      check("sw_rst_state", 32'(state), 32'd0);
      check("sw_rst_memwrite", 32'(MemWrite), 32'd0);
      check("sw_rst_pcwrite", 32'(PCWrite), 32'd0);

      // bne with zero=0.
      reset = 1'b1; mem_ready = 1'b1; opcode = 6'b000101; zero = 1'b0;
      next_cycle(); #1;
      check("bne_decode", 32'(state), 32'd1);
      next_cycle(); #1;
`ifdef MULTICYCLE_BNE_EN
      check("bne_branch", 32'(state), 32'd8);
      check("bne_pcwrite", 32'(PCWrite), 32'd1);
`else
      check("bne_illegal", 32'(state), 32'd0);
      check("bne_no_regwrite", 32'(RegWrite), 32'd0);
`endif

      // Random instruction stream against the path model.
      for (int n = 0; n < 60; n++) begin
         logic [5:0] op, fn;
         logic z;
         op = op_list[$urandom_range(0, 9)];
         fn = fn_list[$urandom_range(0, 5)];
         z  = 1'($urandom_range(0, 1));
         if (!mem_phase(F, pick_wait(), z, op, fn)) continue;
         push_cyc(D, 1'b1, z, op, fn);
         case (op)
            6'b000000: begin push_cyc(EX, 1'b1, z, op, fn); push_cyc(AWB, 1'b1, z, op, fn); end
            6'b100011, 6'b100000, 6'b100100: begin
               push_cyc(MA, 1'b1, z, op, fn);
               if (mem_phase(MR, pick_wait(), z, op, fn)) push_cyc(MWB, 1'b1, z, op, fn);
            end
            6'b101011: begin
               push_cyc(MA, 1'b1, z, op, fn);
               void'(mem_phase(MW, pick_wait(), z, op, fn));
            end
            6'b000100: push_cyc(BR, 1'b1, z, op, fn);
`ifdef MULTICYCLE_BNE_EN
            6'b000101: push_cyc(BR, 1'b1, z, op, fn);
`endif
            6'b001000: begin push_cyc(AIE, 1'b1, z, op, fn); push_cyc(AIW, 1'b1, z, op, fn); end
            6'b000010: push_cyc(JP, 1'b1, z, op, fn);
            default: ;
         endcase
      end
      push_cyc(F, 1'b0, 1'b0, 6'b000000, 6'b000000);

      reset = 1'b0;
      next_cycle();
      reset = 1'b1;
      foreach (q[k]) begin
         mem_ready = q[k].rdy; zero = q[k].z; opcode = q[k].op; funct = q[k].fn;
         #1;
         check($sformatf("rnd_state[%0d]", k), 32'(state), 32'(q[k].st));
         check($sformatf("rnd_outs[%0d]", k), 32'(act),
               32'(exp_outs(q[k].st, q[k].op, q[k].fn, q[k].z, q[k].rdy)));
         check($sformatf("rnd_tmo[%0d]", k), 32'(mem_timeout), 32'(q[k].tmo));
         next_cycle();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #5ms;
      $display("FAIL watchdog expired before summary");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/multicycle_controller.md
Name: multicycle_controller

Overview:
- Multicycle MIPS control unit; next generation of the single-cycle controller.
- Moore FSM sequences fetch/decode/execute/memory/writeback over several cycles and shares one memory port and one ALU.
- Memory states wait on a ready handshake, with a bounded timeout.
- Drives the multicycle datapath; embeds the ALU decode and the byte-load decode (lb/lbu).

Parameters:
- ALUC_W, 3, alucontrol width; codes occupy bits [2:0], upper bits are zero.
- TIMEOUT, 16, maximum wait cycles in a memory state before abort (≥2).
- CNT_W, 5, wait-counter width; must satisfy 2^CNT_W > TIMEOUT.

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  synchronous, active-low reset
- opcode  in  6  instruction register [31:26]
- funct  in  6  instruction register [5:0]
- zero  in  1  ALU zero flag
- mem_ready  in  1  memory completes the current access this cycle
- MemRead  out  1  memory read request
- MemWrite  out  1  memory write request
- IorD  out  1  0 = PC address, 1 = ALUOut address
- IRWrite  out  1  load instruction register
- RegDst  out  1  1 = rd, 0 = rt
- MemToReg  out  1  1 = data register, 0 = ALUOut
- RegWrite  out  1  register file write
- ALUSrcA  out  1  0 = PC, 1 = A
- ALUSrcB  out  2  00 = B, 01 = 4, 10 = SignImm, 11 = SignImm<<2
- PCSrc  out  2  00 = ALUResult, 01 = ALUOut, 10 = jump target
- PCWrite  out  1  final PC enable (unconditional OR branch-taken)
- alucontrol  out  ALUC_W  ALU operation
- LoadByte  out  2  00 = word, 01 = lb, 10 = lbu; valid in MEMWB
- mem_timeout  out  1  one-cycle pulse on memory abort
- state  out  4  current state code, for debug

Behaviour:
- Reset: reset low at a clock edge → state FETCH, wait counter 0. All outputs are the FETCH decode except PCWrite=0 and IRWrite=0 (mem_ready is masked during the reset cycle); mem_timeout=0.
- States and codes:
  - FETCH 0, DECODE 1, MEMADR 2, MEMRD 3, MEMWB 4, MEMWR 5
  - EXEC 6, ALUWB 7, BRANCH 8, ADDIEX 9, ADDIWB 10, JUMP 11
- Any output not listed for a state is 0.
- FETCH:
  - MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, alucontrol=add.
  - IRWrite=PCWrite=mem_ready.
  - mem_ready=1 → DECODE; otherwise stay.
- DECODE: ALUSrcA=0, ALUSrcB=11, alucontrol=add. Next state by opcode:
  - 000000 (R-type) → EXEC
  - 100011, 101011, 100000, 100100 (lw, sw, lb, lbu) → MEMADR
  - 000100 (beq) → BRANCH
  - 001000 (addi) → ADDIEX
  - 000010 (j) → JUMP
  - any other opcode → FETCH; no architectural write
- MEMADR: ALUSrcA=1, ALUSrcB=10, add. sw → MEMWR; otherwise → MEMRD.
- MEMRD: MemRead=1, IorD=1. mem_ready → MEMWB.
- MEMWB:
  - RegDst=0, MemToReg=1, RegWrite=1 → FETCH.
  - LoadByte=01 for 100000, 10 for 100100, 00 otherwise.
- MEMWR: MemWrite=1, IorD=1. mem_ready → FETCH.
- EXEC: ALUSrcA=1, ALUSrcB=00, alucontrol from funct → ALUWB.
- ALUWB: RegDst=1, MemToReg=0, RegWrite=1 → FETCH.
- BRANCH: ALUSrcA=1, ALUSrcB=00, sub, PCSrc=01, PCWrite=zero → FETCH.
- ADDIEX: ALUSrcA=1, ALUSrcB=10, add → ADDIWB.
- ADDIWB: RegDst=0, MemToReg=0, RegWrite=1 → FETCH.
- JUMP: PCSrc=10, PCWrite=1 → FETCH.
- ALU codes:
  - add=010, sub=110, and=000, or=001, slt=111.
  - funct map: 100000 → add, 100010 → sub, 100100 → and, 100101 → or, 101010 → slt, other → add.
- Wait counter (FETCH, MEMRD, MEMWR only):
  - Cleared on state entry and on mem_ready.
  - Increments each cycle the state holds without mem_ready.
  - Counter reaches TIMEOUT-1 with mem_ready still low → next state FETCH, counter 0, mem_timeout=1 for the next cycle.
  - Abort performs no IRWrite, PCWrite or RegWrite.
  - mem_ready on the final allowed cycle wins over timeout.
- Reset takes priority over all transitions, including mid-access.
- Latency with mem_ready held high: R-type 4 cycles, addi 4, lw/lb/lbu 5, sw 4, beq 3, j 3.

Optional Feature:
- Macro MULTICYCLE_BNE_EN.
- Defined: opcode 000101 (bne) → BRANCH with PCWrite=~zero.
- Undefined: 000101 is treated as an illegal opcode (DECODE → FETCH).

Test Plan:
- reset low 2 cycles, then high, mem_ready=1 → state=0, MemRead=1, PCWrite=1, IRWrite=1 on the first post-reset cycle.
- R-type funct 101010, mem_ready=1 → states 0,1,6,7,0; alucontrol=111 in EXEC; RegWrite=1, RegDst=1 in ALUWB.
- lb (100000), mem_ready low 3 cycles in MEMRD → MEMRD held 4 cycles, then MEMWB with LoadByte=01, RegWrite=1.
- beq with zero=1 → PCWrite=1, PCSrc=01 in BRANCH; with zero=0 → PCWrite=0.
- mem_ready stuck low in FETCH with TIMEOUT=16 → 16 FETCH cycles, then mem_timeout=1 for one cycle, no IRWrite; opcode 111111 → DECODE → FETCH with no RegWrite.
- Reset asserted during MEMWR → next state FETCH, MemWrite=0 that cycle; with MULTICYCLE_BNE_EN, bne and zero=0 → PCWrite=1.
